// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: one-hot active-low row drive, frame-level debounce, valid/ready key events.
// Define KEYPAD_SCANNER_RELEASE_EVENT_EN to emit release events via a one-entry pending slot.
`timescale 1ns/1ps
module keypad_scanner #(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int SETTLE_WIDTH = 10,
    parameter int STABLE_SCANS = 4
) (
    input  logic                            clock,
    input  logic                            reset_n,
    output logic [ROWS-1:0]                 row_n,
    input  logic [COLS-1:0]                 col_n,
    output logic                            key_valid,
    input  logic                            key_ready,
    output logic [$clog2(ROWS*COLS)-1:0]    key_code,
    output logic                            key_release,
    output logic                            event_dropped
);
    localparam int KEYS   = ROWS * COLS;
    localparam int CODE_W = $clog2(KEYS);
    localparam int ROW_W  = $clog2(ROWS);
    localparam int STAB_W = $clog2(STABLE_SCANS + 1);

    logic [COLS-1:0]         col_meta, col_sync;
    logic                    active, frame_end;
    logic [SETTLE_WIDTH-1:0] dwell;
    logic [ROW_W-1:0]        row_idx, row_next;
    logic [KEYS-1:0]         image;
    logic                    cand_valid, prev_valid, commit_valid;
    logic [CODE_W-1:0]       cand_code, prev_code, commit_code, hit_code;
    logic [STAB_W-1:0]       stable_cnt, stable_next;
    logic                    ghost, commit, ev_press;
    int unsigned             hits;
    logic                    nxt_valid, drop;
    logic [CODE_W-1:0]       nxt_code;
`ifdef KEYPAD_SCANNER_RELEASE_EVENT_EN
    logic                    ev_release, nxt_release;
    logic                    pend_valid, pend_release, nxt_pend_valid, nxt_pend_release;
    logic [CODE_W-1:0]       pend_code, nxt_pend_code;
`endif

    assign row_next = (row_idx == ROW_W'(ROWS - 1)) ? '0 : row_idx + 1'b1;

    always_comb begin
        hits     = 0;
        hit_code = '0;
        for (int unsigned i = 0; i < KEYS; i++) begin
            if (image[i]) begin
                hits     = hits + 1;
                hit_code = CODE_W'(i);
            end
        end
    end

    // A multi-key frame reuses the previous candidate and leaves the stability count untouched.
    assign ghost      = (hits > 1);
    assign cand_valid = ghost ? prev_valid : (hits == 1);
    assign cand_code  = ghost ? prev_code  : hit_code;

    always_comb begin
        if (ghost)
            stable_next = stable_cnt;
        else if (cand_valid == prev_valid && cand_code == prev_code)
            stable_next = (stable_cnt == STAB_W'(STABLE_SCANS)) ? stable_cnt : stable_cnt + 1'b1;
        else
            stable_next = STAB_W'(1);
    end

    assign commit   = frame_end && !ghost && (stable_next == STAB_W'(STABLE_SCANS)) &&
                      (cand_valid != commit_valid || cand_code != commit_code);
    assign ev_press = commit && cand_valid;

    // Output register is filled first, then the pending slot; anything left over is dropped.
    always_comb begin
        nxt_valid = key_valid && !key_ready;
        nxt_code  = key_code;
        drop      = 1'b0;
`ifdef KEYPAD_SCANNER_RELEASE_EVENT_EN
        nxt_release      = key_release;
        nxt_pend_valid   = pend_valid;
        nxt_pend_code    = pend_code;
        nxt_pend_release = pend_release;
        if (!nxt_valid && nxt_pend_valid) begin
            nxt_valid      = 1'b1;
            nxt_code       = nxt_pend_code;
            nxt_release    = nxt_pend_release;
            nxt_pend_valid = 1'b0;
        end
        if (ev_release) begin
            if (!nxt_valid) begin
                nxt_valid   = 1'b1;
                nxt_code    = commit_code;
                nxt_release = 1'b1;
            end else if (!nxt_pend_valid) begin
                nxt_pend_valid   = 1'b1;
                nxt_pend_code    = commit_code;
                nxt_pend_release = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end
        if (ev_press) begin
            if (!nxt_valid) begin
                nxt_valid   = 1'b1;
                nxt_code    = cand_code;
                nxt_release = 1'b0;
            end else if (!nxt_pend_valid) begin
                nxt_pend_valid   = 1'b1;
                nxt_pend_code    = cand_code;
                nxt_pend_release = 1'b0;
            end else begin
                drop = 1'b1;
            end
        end
`else
        if (ev_press) begin
            if (!nxt_valid) begin
                nxt_valid = 1'b1;
                nxt_code  = cand_code;
            end else begin
                drop = 1'b1;
            end
        end
`endif
    end

`ifdef KEYPAD_SCANNER_RELEASE_EVENT_EN
    assign ev_release = commit && commit_valid;
`else
    assign key_release = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            col_meta      <= '1;
            col_sync      <= '1;
            active        <= 1'b0;
            frame_end     <= 1'b0;
            dwell         <= '0;
            row_idx       <= '0;
            row_n         <= '1;
            image         <= '0;
            prev_valid    <= 1'b0;
            prev_code     <= '0;
            commit_valid  <= 1'b0;
            commit_code   <= '0;
            stable_cnt    <= '0;
            key_valid     <= 1'b0;
            key_code      <= '0;
            event_dropped <= 1'b0;
`ifdef KEYPAD_SCANNER_RELEASE_EVENT_EN
            key_release   <= 1'b0;
            pend_valid    <= 1'b0;
            pend_code     <= '0;
            pend_release  <= 1'b0;
`endif
        end else begin
            col_meta  <= col_n;
            col_sync  <= col_meta;
            frame_end <= 1'b0;
            if (!active) begin
                active <= 1'b1;
                row_n  <= ~ROWS'(1);
            end else if (&dwell) begin
                for (int unsigned r = 0; r < ROWS; r++) begin
                    if (row_idx == ROW_W'(r))
                        image[r*COLS +: COLS] <= ~col_sync;
                end
                frame_end <= (row_idx == ROW_W'(ROWS - 1));
                row_idx   <= row_next;
                dwell     <= '0;
                row_n     <= ~(ROWS'(1) << row_next);
            end else begin
                dwell <= dwell + 1'b1;
            end
            if (frame_end) begin
                prev_valid <= cand_valid;
                prev_code  <= cand_code;
                stable_cnt <= stable_next;
            end
            if (commit) begin
                commit_valid <= cand_valid;
                commit_code  <= cand_code;
            end
            key_valid     <= nxt_valid;
            key_code      <= nxt_code;
            event_dropped <= drop;
`ifdef KEYPAD_SCANNER_RELEASE_EVENT_EN
            key_release  <= nxt_release;
            pend_valid   <= nxt_pend_valid;
            pend_code    <= nxt_pend_code;
            pend_release <= nxt_pend_release;
`endif
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner on a 4x4 pad with a 16-clock frame and 3-frame debounce.
`timescale 1ns/1ps
module tb_keypad_scanner;
    localparam int FRAME = 16;

    typedef struct packed {
        logic [3:0] code;
        logic       rel;
    } ev_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic        key_valid;
    logic        key_ready = 1'b0;
    logic [3:0]  key_code;
    logic        key_release;
    logic        event_dropped;
    logic [15:0] keys = '0;

    int  total = 0;
    int  bad = 0;
    int  drop_cnt = 0;
    int  ev_cnt = 0;
    ev_t exp_q[$];
    ev_t mon_e;

    keypad_scanner #(
        .ROWS(4),
        .COLS(4),
        .SETTLE_WIDTH(2),
        .STABLE_SCANS(3)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .row_n(row_n),
        .col_n(col_n),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .key_code(key_code),
        .key_release(key_release),
        .event_dropped(event_dropped)
    );

    always #5 clock = ~clock;

    // Passive keypad: a pressed key shorts its row drive onto its column.
    always_comb begin
        col_n = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!row_n[r] && keys[r*4+c]) col_n[c] = 1'b0;
    end

    always @(negedge clock) begin
        if (reset_n && event_dropped) drop_cnt++;
        if (reset_n && key_valid && key_ready) begin
            ev_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event: got code=%0d rel=%0b, required no event", key_code, key_release);
            end else begin
                mon_e = exp_q.pop_front();
                if (key_code !== mon_e.code || key_release !== mon_e.rel) begin
                    bad++;
                    $display("FAIL event_order: got code=%0d rel=%0b, required code=%0d rel=%0b",
                             key_code, key_release, mon_e.code, mon_e.rel);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_frames(input int n);
        repeat (n * FRAME) tick();
    endtask

    task automatic test_reset();
        logic [3:0] one;
        logic [3:0] exp_row;
        one = 4'b0001;
        reset_n = 1'b0;
        keys = '0;
        key_ready = 1'b0;
        repeat (3) tick();
        total++;
        if (row_n !== 4'hF || key_valid !== 1'b0 || key_code !== 4'd0 || key_release !== 1'b0 || event_dropped !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: row_n=%b valid=%b code=%0d rel=%b drop=%b, required 1111 0 0 0 0",
                     row_n, key_valid, key_code, key_release, event_dropped);
        end
        reset_n = 1'b1;
        for (int k = 0; k < 32; k++) begin
            tick();
            exp_row = ~(one << ((k / 4) % 4));
            total++;
            if (row_n !== exp_row) begin
                bad++;
                $display("FAIL row_scan[%0d]: got %b, required %b", k, row_n, exp_row);
            end
        end
    endtask

    task automatic test_press_hold();
        int  n;
        int  start;
        bit  steady;
        key_ready = 1'b0;
        exp_q.push_back(ev_t'{code: 4'd9, rel: 1'b0});
        keys = 16'h0200;
        n = 0;
        while (!key_valid && n < 8 * FRAME) begin
            tick();
            n++;
        end
        total++;
        if (!key_valid || n < 2 * FRAME || n > 5 * FRAME) begin
            bad++;
            $display("FAIL press_latency: got valid=%b after %0d clocks, required valid=1 within 32..80", key_valid, n);
        end
        total++;
        if (key_code !== 4'd9 || key_release !== 1'b0) begin
            bad++;
            $display("FAIL press_code: got code=%0d rel=%b, required code=9 rel=0", key_code, key_release);
        end
        steady = 1'b1;
        repeat (100) begin
            tick();
            if (key_valid !== 1'b1 || key_code !== 4'd9 || key_release !== 1'b0) steady = 1'b0;
        end
        total++;
        if (!steady) begin
            bad++;
            $display("FAIL hold_stable: got valid=%b code=%0d, required outputs unchanged for 100 clocks", key_valid, key_code);
        end
        start = ev_cnt;
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        total++;
        if (key_valid !== 1'b0) begin
            bad++;
            $display("FAIL accept_drop: got valid=%b, required 0", key_valid);
        end
        steady = 1'b1;
        repeat (6 * FRAME) begin
            tick();
            if (key_valid !== 1'b0) steady = 1'b0;
        end
        total++;
        if (!steady || ev_cnt != start + 1 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL no_repeat: got events=%0d pending_exp=%0d quiet=%b, required events=%0d pending_exp=0 quiet=1",
                     ev_cnt - start, exp_q.size(), steady, 1);
        end
    endtask

    task automatic test_bounce();
        int start;
        key_ready = 1'b1;
        keys = '0;
`ifdef KEYPAD_SCANNER_RELEASE_EVENT_EN
        exp_q.push_back(ev_t'{code: 4'd9, rel: 1'b1});
`endif
        wait_frames(6);
        start = ev_cnt;
        for (int i = 0; i < 5; i++) begin
            keys = (i % 2 == 0) ? 16'h0200 : 16'h0000;
            wait_frames(1);
        end
        total++;
        if (ev_cnt != start) begin
            bad++;
            $display("FAIL bounce_quiet: got %0d events during toggling, required 0", ev_cnt - start);
        end
        exp_q.push_back(ev_t'{code: 4'd9, rel: 1'b0});
        keys = 16'h0200;
        wait_frames(6);
        total++;
        if (ev_cnt != start + 1 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL bounce_single: got %0d events (pending_exp=%0d), required 1 (pending_exp=0)",
                     ev_cnt - start, exp_q.size());
        end
    endtask

    task automatic test_ghost();
        int start;
        int d0;
        key_ready = 1'b1;
        keys = '0;
`ifdef KEYPAD_SCANNER_RELEASE_EVENT_EN
        exp_q.push_back(ev_t'{code: 4'd9, rel: 1'b1});
`endif
        wait_frames(6);
        start = ev_cnt;
        d0 = drop_cnt;
        keys = 16'h0021;
        wait_frames(10);
        total++;
        if (ev_cnt != start || drop_cnt != d0 || key_valid !== 1'b0) begin
            bad++;
            $display("FAIL ghost_silent: got events=%0d drops=%0d valid=%b, required 0 0 0",
                     ev_cnt - start, drop_cnt - d0, key_valid);
        end
        keys = '0;
        wait_frames(6);
        total++;
        if (ev_cnt != start || exp_q.size() != 0) begin
            bad++;
            $display("FAIL ghost_release: got events=%0d pending_exp=%0d, required 0 0", ev_cnt - start, exp_q.size());
        end
    endtask

`ifdef KEYPAD_SCANNER_RELEASE_EVENT_EN
    task automatic test_release_events();
        int  n;
        bit  seen;
        key_ready = 1'b1;
        exp_q.push_back(ev_t'{code: 4'd9, rel: 1'b0});
        keys = 16'h0200;
        wait_frames(6);
        exp_q.push_back(ev_t'{code: 4'd9, rel: 1'b1});
        keys = '0;
        wait_frames(6);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL press_release: got %0d undelivered, required 0", exp_q.size());
        end
        exp_q.push_back(ev_t'{code: 4'd9, rel: 1'b0});
        keys = 16'h0200;
        wait_frames(6);
        exp_q.push_back(ev_t'{code: 4'd9, rel: 1'b1});
        exp_q.push_back(ev_t'{code: 4'd4, rel: 1'b0});
        keys = 16'h0010;
        wait_frames(6);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL key_switch: got %0d undelivered, required 0", exp_q.size());
        end
        key_ready = 1'b0;
        keys = 16'h0200;
        n = 0;
        while (!key_valid && n < 8 * FRAME) begin
            tick();
            n++;
        end
        total++;
        if (key_valid !== 1'b1 || key_code !== 4'd4 || key_release !== 1'b1) begin
            bad++;
            $display("FAIL switch_release: got valid=%b code=%0d rel=%b, required 1 4 1", key_valid, key_code, key_release);
        end
        repeat (3) tick();
        reset_n = 1'b0;
        keys = '0;
        #1;
        total++;
        if (row_n !== 4'hF || key_valid !== 1'b0 || key_code !== 4'd0 || key_release !== 1'b0 || event_dropped !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: row_n=%b valid=%b code=%0d rel=%b drop=%b, required 1111 0 0 0 0",
                     row_n, key_valid, key_code, key_release, event_dropped);
        end
        repeat (3) tick();
        reset_n = 1'b1;
        key_ready = 1'b1;
        seen = 1'b0;
        repeat (8 * FRAME) begin
            tick();
            if (key_valid) seen = 1'b1;
        end
        total++;
        if (seen || exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_discard: got valid_seen=%b pending_exp=%0d, required 0 0", seen, exp_q.size());
        end
    endtask
`else
    task automatic test_backpressure();
        int d0;
        int start;
        key_ready = 1'b0;
        exp_q.push_back(ev_t'{code: 4'd3, rel: 1'b0});
        keys = 16'h0008;
        wait_frames(6);
        total++;
        if (key_valid !== 1'b1 || key_code !== 4'd3) begin
            bad++;
            $display("FAIL bp_first: got valid=%b code=%0d, required 1 3", key_valid, key_code);
        end
        keys = '0;
        wait_frames(6);
        d0 = drop_cnt;
        keys = 16'h0080;
        wait_frames(6);
        total++;
        if (key_valid !== 1'b1 || key_code !== 4'd3 || key_release !== 1'b0 || drop_cnt != d0 + 1) begin
            bad++;
            $display("FAIL bp_drop: got valid=%b code=%0d rel=%b drops=%0d, required 1 3 0 1",
                     key_valid, key_code, key_release, drop_cnt - d0);
        end
        start = ev_cnt;
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        wait_frames(2);
        total++;
        if (key_valid !== 1'b0 || ev_cnt != start + 1 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL bp_drain: got valid=%b events=%0d pending_exp=%0d, required 0 1 0",
                     key_valid, ev_cnt - start, exp_q.size());
        end
        key_ready = 1'b1;
        keys = '0;
        wait_frames(6);
        total++;
        if (ev_cnt != start + 1) begin
            bad++;
            $display("FAIL bp_silent_release: got events=%0d, required 1", ev_cnt - start);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_press_hold();
        test_bounce();
        test_ghost();
`ifdef KEYPAD_SCANNER_RELEASE_EVENT_EN
        test_release_events();
`else
        test_backpressure();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish by 2ms, required finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Matrix-keypad controller: drives one row low at a time, samples the active-low columns and debounces by requiring whole-scan agreement across frames.
- Emits key events (code plus press/release) on a valid/ready handshake to the display-control logic.
- Only one row dwell counter and one stability counter are used, whatever the key count.

Parameters:
- ROWS, 4, number of keypad rows (2..8)
- COLS, 4, number of keypad columns (2..8)
- SETTLE_WIDTH, 10, row dwell = 2^SETTLE_WIDTH clocks
- STABLE_SCANS, 4, consecutive identical frames required to commit a change (>=2)

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- row_n  out  ROWS  row drives, active-low, at most one bit low
- col_n  in  COLS  raw column inputs, active-low (pulled up), asynchronous
- key_valid  out  1  event available
- key_ready  in  1  consumer accepts event
- key_code  out  $clog2(ROWS*COLS)  code = row*COLS + col
- key_release  out  1  1 = release event (always 0 without the macro)
- event_dropped  out  1  one-cycle pulse when an event is lost

Behaviour:
- Reset values:
  - row_n all ones; key_valid, key_code, key_release, event_dropped all 0.
  - Internal state: row index 0, dwell 0, committed = none, previous candidate = none, stable count 0, pending cleared.
- Reset asserted mid-frame or mid-handshake:
  - Everything returns to reset values asynchronously.
  - A pending event is discarded.
- Column synchroniser: col_n passes through 2 flops before use.
- Scan:
  - The first clock after reset release drives row 0 (row_n = ~1).
  - The dwell counter runs 0..2^SETTLE_WIDTH-1.
  - On terminal count:
    - latch ~col_sync into image row r;
    - advance r (wrapping ROWS-1 -> 0) and clear dwell.
  - Frame length = ROWS*2^SETTLE_WIDTH clocks.
  - Scanning never stalls for backpressure.
- End of frame (cycle after the last row's sample):
  - Candidate is:
    - exactly one image bit set -> pressed with that code;
    - zero bits set -> none;
    - more than one bit set (ghosting) -> previous candidate reused (a multi-key frame neither advances nor breaks stability).
  - Stability counting:
    - candidate == previous candidate -> stable count increments, saturating at STABLE_SCANS;
    - otherwise stable count = 1.
  - Commit when stable count reaches STABLE_SCANS and the candidate differs from committed:
    - none -> K: press event K;
    - K -> none: release event K (macro only), otherwise silent;
    - K -> J: press event J (macro also releases K first, see below).
  - A held key produces exactly one press event (no auto-repeat).
- Handshake:
  - key_valid rises 1 cycle after the committing frame end.
  - key_code and key_release stay stable while key_valid && !key_ready.
  - On key_valid && key_ready, key_valid drops next cycle, unless a pending event is loaded in that same cycle.
- Overflow:
  - A new event generated while key_valid=1 (and the pending slot full, when the slot exists) is discarded.
  - event_dropped pulses for 1 cycle.
  - The committed state still updates.
- Simultaneous accept and new event in the same cycle: the new event is loaded directly and nothing is dropped.

Optional Feature:
- KEYPAD_SCANNER_RELEASE_EVENT_EN defined:
  - K -> none emits a release event (key_code=K, key_release=1).
  - K -> J emits release K, then press J.
  - Press J is held in a single pending slot and presented the cycle after release K is accepted.
- Undefined:
  - key_release tied 0; releases only clear committed state.
  - K -> J emits press J only; no pending slot.

Test Plan (SETTLE_WIDTH=2, STABLE_SCANS=3, 4x4; frame = 16 clocks):
1. Reset:
   - Hold reset_n=0 -> row_n=4'b1111, key_valid=0.
   - Release -> row_n steps 1110, 1101, 1011, 0111, each for 4 clocks, repeating.
2. Press row2/col1 held steady with key_ready=0:
   - key_valid=1, key_code=9, key_release=0 one cycle after the 3rd matching frame ends.
   - Outputs hold unchanged 100 clocks.
   - key_ready=1 for 1 cycle -> key_valid=0 next cycle.
   - No further events while held.
3. Bounce: key 9 toggled every frame for 5 frames, then held -> exactly one event (code 9); no event during the toggling.
4. Keys 0 and 5 pressed together for 10 frames from idle -> no event, event_dropped stays 0.
5. Backpressure, key_ready=0, macro undefined:
   - press 3 (stable), release, press 7 (stable) -> key_code stays 3.
   - event_dropped pulses exactly once (for the press of 7).
6. Macro defined, key_ready=1:
   - press 9, release -> events (9,0) then (9,1).
   - press 9 -> 4 directly -> (9,0), then (9,1), then (4,0).
   - reset_n low mid-frame with a pending event -> all outputs 0 and no event after reset.
